// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage constants and the fetch FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_pc_unit_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'd4;

    // RUN: normal fetch; PEND: a redirect is parked until the stall drops
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

    // Force a branch target onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: pipeline control and imem data in, PC and IF/ID contents out.
// Latency: n/a (wiring only).
// Backpressure: Stall freezes the fetch unit; there is no ready back to the driver.
interface fetch_pc_unit_if #(
    parameter int DATA_W = 32
);
    logic              Stall;
    logic              BranchTaken;
    logic [DATA_W-1:0] BranchTarget;
    logic [DATA_W-1:0] InstrIn;
    logic [DATA_W-1:0] PcOut;
    logic [DATA_W-1:0] IfIdPcPlus4;
    logic [DATA_W-1:0] IfIdInstr;
    logic              IfIdValid;
    logic              RedirectPending;
    logic              AlignErr;

    // Driver side: hazard unit, EX stage and instruction memory
    modport master (
        output Stall, BranchTaken, BranchTarget, InstrIn,
        input  PcOut, IfIdPcPlus4, IfIdInstr, IfIdValid, RedirectPending, AlignErr
    );

    // Fetch unit side
    modport slave (
        input  Stall, BranchTaken, BranchTarget, InstrIn,
        output PcOut, IfIdPcPlus4, IfIdInstr, IfIdValid, RedirectPending, AlignErr
    );
endinterface

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: PC+4, instruction and valid bit of the fetched slot.
// Latency: 1 cycle from fetch to register output.
// Backpressure: hold freezes contents; flush writes a bubble; hold beats flush.
module if_id_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] instr,
    output logic              valid
);

    // Reset > hold > flush > capture a fresh fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_plus4 <= '0;
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else if (hold) begin
            pc_plus4 <= pc_plus4;
            instr    <= instr;
            valid    <= valid;
        end else if (flush) begin
            pc_plus4 <= '0;
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else begin
            pc_plus4 <= pc_plus4_in;
            instr    <= instr_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, PC+4 incrementer, one-entry redirect buffer and IF/ID register.
// Latency: 1 cycle for sequential fetch and for a branch redirect.
// Backpressure: Stall freezes PC and IF/ID; a branch seen during a stall is parked and applied when Stall drops.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int          DATA_W    = DATA_W_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    fetch_pc_unit_if.slave       bus
);

    fetch_state_t      state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] eff_tgt;
    logic [DATA_W-1:0] pend_tgt;
    logic              pending;
    logic              align_err;
    logic              flush;

    // Wraps naturally mod 2^DATA_W; low bits of a target are dropped, not trusted
    assign pc_plus4 = pc + PC_STEP;
    assign eff_tgt  = word_align(bus.BranchTarget);

    // A redirect lands whenever the front end moves: live branch or a parked one
    assign flush = !bus.Stall && (bus.BranchTaken || (state == PEND));

    // PC, redirect buffer and FSM; a live branch always beats the parked target
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            pend_tgt <= '0;
            pending  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.Stall) begin
                        pc <= bus.BranchTaken ? eff_tgt : pc_plus4;
                    end else if (bus.BranchTaken) begin
                        pend_tgt <= eff_tgt;
                        pending  <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (bus.Stall) begin
                        if (bus.BranchTaken) begin
                            pend_tgt <= eff_tgt;
                        end
                    end else begin
                        pc      <= bus.BranchTaken ? eff_tgt : pend_tgt;
                        pending <= 1'b0;
                        state   <= RUN;
                    end
                end
                default: begin
                    state   <= RUN;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for any misaligned taken-branch target, cleared only by reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            align_err <= 1'b0;
        end else if (bus.BranchTaken && (bus.BranchTarget[1:0] != 2'b00)) begin
            align_err <= 1'b1;
        end
    end

    if_id_reg #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (Clk),
        .rst_n       (Reset),
        .hold        (bus.Stall),
        .flush       (flush),
        .pc_plus4_in (pc_plus4),
        .instr_in    (bus.InstrIn),
        .pc_plus4    (bus.IfIdPcPlus4),
        .instr       (bus.IfIdInstr),
        .valid       (bus.IfIdValid)
    );

    assign bus.PcOut           = pc;
    assign bus.RedirectPending = pending;
    assign bus.AlignErr        = align_err;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, redirects, stalls, alignment, wrap, reset.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: Stall driven directly by the bench.
module tb_fetch_pc_unit;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    fetch_pc_unit_if #(.DATA_W(32)) bus ();

    fetch_pc_unit u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Instruction memory model: word at address a reads as 0xA0 + a
    assign bus.InstrIn = 32'h0000_00A0 + bus.PcOut;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic stall, input logic bt, input logic [31:0] tgt);
        bus.Stall        = stall;
        bus.BranchTaken  = bt;
        bus.BranchTarget = tgt;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b0;
        set_in(1'b0, 1'b0, 32'h0);

        // 1: reset, then sequential fetch
        step();
        step();
        chk("rst_pc",      bus.PcOut,           32'h0);
        chk("rst_plus4",   bus.IfIdPcPlus4,     32'h0);
        chk("rst_instr",   bus.IfIdInstr,       32'h0);
        chk("rst_valid",   {31'b0, bus.IfIdValid},       32'h0);
        chk("rst_pend",    {31'b0, bus.RedirectPending}, 32'h0);
        chk("rst_align",   {31'b0, bus.AlignErr},        32'h0);
        Reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc",    bus.PcOut,       32'(4 * i));
            chk("seq_plus4", bus.IfIdPcPlus4, 32'(4 * i));
            chk("seq_instr", bus.IfIdInstr,   32'(32'hA0 + 4 * (i - 1)));
            chk("seq_valid", {31'b0, bus.IfIdValid}, 32'h1);
        end

        // 2: taken branch with no stall
        set_in(1'b0, 1'b1, 32'h100);
        step();
        chk("br_pc",    bus.PcOut,       32'h100);
        chk("br_valid", {31'b0, bus.IfIdValid}, 32'h0);
        chk("br_instr", bus.IfIdInstr,   32'h0);
        chk("br_plus4", bus.IfIdPcPlus4, 32'h0);
        set_in(1'b0, 1'b0, 32'h0);
        step();
        chk("br_next_pc",    bus.PcOut,       32'h104);
        chk("br_next_plus4", bus.IfIdPcPlus4, 32'h104);
        chk("br_next_instr", bus.IfIdInstr,   32'h1A0);
        chk("br_next_valid", {31'b0, bus.IfIdValid}, 32'h1);

        // 3: branch captured during a 3-cycle stall
        set_in(1'b1, 1'b1, 32'h200);
        step();
        chk("stl_pend1", {31'b0, bus.RedirectPending}, 32'h1);
        chk("stl_pc1",   bus.PcOut, 32'h104);
        set_in(1'b1, 1'b0, 32'h0);
        step();
        step();
        chk("stl_pc3",    bus.PcOut,       32'h104);
        chk("stl_plus4",  bus.IfIdPcPlus4, 32'h104);
        chk("stl_valid",  {31'b0, bus.IfIdValid}, 32'h1);
        chk("stl_pend3",  {31'b0, bus.RedirectPending}, 32'h1);
        set_in(1'b0, 1'b0, 32'h0);
        step();
        chk("pend_pc",    bus.PcOut, 32'h200);
        chk("pend_clr",   {31'b0, bus.RedirectPending}, 32'h0);
        chk("pend_valid", {31'b0, bus.IfIdValid}, 32'h0);
        step();
        chk("pend_next_pc", bus.PcOut,       32'h204);
        chk("pend_next_p4", bus.IfIdPcPlus4, 32'h204);

        // 4a: live branch beats the parked target
        set_in(1'b1, 1'b1, 32'h280);
        step();
        set_in(1'b0, 1'b1, 32'h300);
        step();
        chk("live_pc",   bus.PcOut, 32'h300);
        chk("live_pend", {31'b0, bus.RedirectPending}, 32'h0);

        // 4b: newest parked target wins
        set_in(1'b1, 1'b1, 32'h200);
        step();
        set_in(1'b1, 1'b1, 32'h240);
        step();
        set_in(1'b1, 1'b0, 32'h0);
        step();
        set_in(1'b0, 1'b0, 32'h0);
        step();
        chk("ovr_pc", bus.PcOut, 32'h240);

        // 5: misaligned target
        chk("align_pre", {31'b0, bus.AlignErr}, 32'h0);
        set_in(1'b0, 1'b1, 32'h1002);
        step();
        chk("mis_pc",    bus.PcOut, 32'h1000);
        chk("mis_align", {31'b0, bus.AlignErr}, 32'h1);
        set_in(1'b0, 1'b0, 32'h0);
        step();
        step();
        chk("mis_pc2",    bus.PcOut, 32'h1008);
        chk("mis_sticky", {31'b0, bus.AlignErr}, 32'h1);

        // 6: wrap at top of address space, then reset during PEND
        set_in(1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        chk("wrap_tgt", bus.PcOut, 32'hFFFF_FFFC);
        set_in(1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_pc",    bus.PcOut,       32'h0);
        chk("wrap_plus4", bus.IfIdPcPlus4, 32'h0);
        chk("wrap_instr", bus.IfIdInstr,   32'h9C);
        chk("wrap_valid", {31'b0, bus.IfIdValid}, 32'h1);
        set_in(1'b1, 1'b1, 32'h500);
        step();
        chk("pre_rst_pend", {31'b0, bus.RedirectPending}, 32'h1);
        Reset = 1'b0;
        step();
        chk("prst_pc",    bus.PcOut, 32'h0);
        chk("prst_pend",  {31'b0, bus.RedirectPending}, 32'h0);
        chk("prst_align", {31'b0, bus.AlignErr},        32'h0);
        chk("prst_valid", {31'b0, bus.IfIdValid},       32'h0);
        Reset = 1'b1;
        set_in(1'b0, 1'b0, 32'h0);
        step();
        chk("prst_abort", bus.PcOut, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
